// File: rtl/core_dmem_resp.sv
// core_dmem_resp: data-memory responder for the RV32I memory stage.
// Captures a single-cycle load/store request, waits WAIT_CYCLES, performs
// the SRAM access, then pulses DONE (and ERR on a bad request) for one
// cycle. Load data is lane-extracted and sign/zero-extended.
// Optional protocol checker enabled by defining DMEM_RESP_PROTCHK_EN.
module core_dmem_resp #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        NRST,
  input  logic        ISLOAD_SS,
  input  logic        ISSTORE_SS,
  input  logic [31:0] DMEM_ADDR,
  input  logic [31:0] DMEM_WDATA,
  input  logic [3:0]  STRB,
  input  logic        ISLOADBS,
  input  logic        ISLOADHWS,
  output logic [31:0] DMEM_RDATA,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR
`ifdef DMEM_RESP_PROTCHK_EN
  ,
  output logic        PROT_VIOL
`endif
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             done_q, err_q;
  logic [31:0]      rdata_q;

  logic [31:0]      addr_q, wdata_q;
  logic [3:0]       strb_q;
  logic             bs_q, hws_q, is_load_q, is_store_q, both_q;

  logic [31:0]      mem_q [DEPTH_WORDS];

  logic             strobe;
  logic [1:0]       off;
  logic [IDX_W-1:0] idx;
  logic             in_range, req_err;
  logic [31:0]      rd_word, ld_result;

  // Byte strobes must form a byte, halfword or word lane matching the offset.
  function automatic logic strb_ok(input logic [3:0] s, input logic [1:0] o);
    case (s)
      4'b1111: return (o == 2'd0);
      4'b0011: return (o == 2'd0);
      4'b1100: return (o == 2'd2);
      4'b0001: return (o == 2'd0);
      4'b0010: return (o == 2'd1);
      4'b0100: return (o == 2'd2);
      4'b1000: return (o == 2'd3);
      default: return 1'b0;
    endcase
  endfunction

  // Right-justify the addressed lane and extend it.
  function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [3:0] s,
                                               input logic [1:0] o, input logic sb,
                                               input logic sh);
    logic [31:0] shv;
    shv = w >> {o, 3'b000};
    if (s == 4'b1111) return w;
    else if (s == 4'b0011 || s == 4'b1100)
      return sh ? {{16{shv[15]}}, shv[15:0]} : {16'h0000, shv[15:0]};
    else
      return sb ? {{24{shv[7]}}, shv[7:0]} : {24'h000000, shv[7:0]};
  endfunction

  assign strobe     = ISLOAD_SS | ISSTORE_SS;
  // Stall must take effect in the request cycle itself, hence the direct strobe term.
  assign BUSY       = (state_q == S_IDLE && strobe) || state_q == S_WAIT || state_q == S_ACCESS;
  assign DONE       = done_q;
  assign ERR        = err_q;
  assign DMEM_RDATA = rdata_q;

  // Decode the captured request: word index, error conditions and load result.
  always_comb begin
    off       = addr_q[1:0];
    idx       = addr_q[IDX_W+1:2];
    in_range  = (addr_q[31:IDX_W+2] == BASE_ADDR[31:IDX_W+2]);
    req_err   = both_q | ~in_range | ~strb_ok(strb_q, off);
    rd_word   = mem_q[idx];
    ld_result = load_extract(rd_word, strb_q, off, bs_q, hws_q);
  end

  // Request capture; only meaningful while a request is in flight, so no reset.
  always_ff @(posedge CLK) begin
    if (state_q == S_IDLE && strobe) begin
      addr_q     <= DMEM_ADDR;
      wdata_q    <= DMEM_WDATA;
      strb_q     <= STRB;
      bs_q       <= ISLOADBS;
      hws_q      <= ISLOADHWS;
      is_load_q  <= ISLOAD_SS;
      is_store_q <= ISSTORE_SS;
      both_q     <= ISLOAD_SS & ISSTORE_SS;
    end
  end

  // SRAM byte-masked write; a reset before ACCESS leaves the array untouched.
  always_ff @(posedge CLK) begin
    if (state_q == S_ACCESS && is_store_q && !req_err) begin
      for (int n = 0; n < 4; n++) begin
        if (strb_q[n]) mem_q[idx][8*n +: 8] <= wdata_q[8*n +: 8];
      end
    end
  end

  // Request sequencer with registered DONE/ERR/RDATA.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (strobe) begin
            if (WAIT_CYCLES > 0) begin
              state_q <= S_WAIT;
              cnt_q   <= CNT_W'(WAIT_CYCLES);
            end else begin
              state_q <= S_ACCESS;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q <= CNT_W'(1)) begin
            state_q <= S_ACCESS;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_ACCESS: begin
          state_q <= S_RESP;
          done_q  <= 1'b1;
          err_q   <= req_err;
          if (is_load_q && !both_q) rdata_q <= req_err ? 32'h0 : ld_result;
        end
        S_RESP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef DMEM_RESP_PROTCHK_EN
  logic strobe_prev_q, prot_q;
  assign PROT_VIOL = prot_q;

  // Sticky flag for strobes while busy or strobes held longer than one cycle.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      strobe_prev_q <= 1'b0;
      prot_q        <= 1'b0;
    end else begin
      strobe_prev_q <= strobe;
      if (strobe && (state_q != S_IDLE || strobe_prev_q)) prot_q <= 1'b1;
    end
  end

`ifndef SYNTHESIS
  int unsigned cyc_q;
  // Cycle counter and violation report for simulation.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) cyc_q <= 0;
    else begin
      cyc_q <= cyc_q + 1;
      if (strobe && (state_q != S_IDLE || strobe_prev_q))
        $display("core_dmem_resp: protocol violation at cycle %0d", cyc_q);
    end
  end
`endif
`endif

endmodule
